// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned A_WIDTH_DEF      = 32;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC0_0000;
    localparam logic [31:0] ROM_BYTES_DEF    = 32'h0000_1000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        STALL = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD     = 2'd0,
        PC_INC      = 2'd1,
        PC_REDIRECT = 2'd2
    } pc_sel_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: ROM port, redirect from execute, IF/ID handshake toward decode.
interface instr_fetch_if #(
    parameter int unsigned A_WIDTH = 32
);
    logic [A_WIDTH-1:0] imem_addr;
    logic [31:0]        imem_data;
    logic               redirect_valid;
    logic [A_WIDTH-1:0] redirect_target;
    logic               id_valid;
    logic               id_ready;
    logic [31:0]        id_instr;
    logic [A_WIDTH-1:0] id_pc;
    logic [A_WIDTH-1:0] id_pc_plus4;
    logic               fetch_fault;

    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_target,
        output id_valid,
        input  id_ready,
        output id_instr,
        output id_pc,
        output id_pc_plus4,
        output fetch_fault
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_target,
        input  id_valid,
        output id_ready,
        input  id_instr,
        input  id_pc,
        input  id_pc_plus4,
        input  fetch_fault
    );
endinterface

// File: rtl/instr_fetch_pc_reg.sv
// Program counter register with hold / +4 / redirect next-PC selection.
module pc_reg
    import fetch_pkg::*;
#(
    parameter int unsigned        A_WIDTH      = A_WIDTH_DEF,
    parameter logic [A_WIDTH-1:0] RESET_VECTOR = A_WIDTH'(RESET_VECTOR_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    input  pc_sel_t            pc_sel,
    input  logic [A_WIDTH-1:0] redirect_target,
    output logic [A_WIDTH-1:0] pc
);

    // Wraps modulo 2^A_WIDTH with no flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_VECTOR;
        end else begin
            case (pc_sel)
                PC_INC:      pc <= pc + A_WIDTH'(4);
                PC_REDIRECT: pc <= redirect_target;
                default:     pc <= pc;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives the ROM address and holds the IF/ID register.
// Optional range/alignment fault checking is enabled by defining FETCH_FAULT_EN.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned        A_WIDTH      = A_WIDTH_DEF,
    parameter logic [A_WIDTH-1:0] RESET_VECTOR = A_WIDTH'(RESET_VECTOR_DEF),
    parameter logic [A_WIDTH-1:0] ROM_BYTES    = A_WIDTH'(ROM_BYTES_DEF)
) (
    input  logic           clk,
    input  logic           rst,
    instr_fetch_if.master  bus
);

    if ((ROM_BYTES < A_WIDTH'(4)) || (ROM_BYTES[1:0] != 2'b00)) begin : g_bad_rom
        $error("ROM_BYTES must be a nonzero multiple of 4");
    end

    fetch_state_t       state_q;
    logic               id_valid_q;
    logic [31:0]        id_instr_q;
    logic [A_WIDTH-1:0] id_pc_q;
    logic [A_WIDTH-1:0] id_pc_plus4_q;
    logic               fault_q;
    logic [A_WIDTH-1:0] pc;

    logic [A_WIDTH-1:0] target_c;
    logic               redirect_ok_c;
    logic               pc_ok_c;
    logic               advance_c;
    pc_sel_t            pc_sel_c;

`ifdef FETCH_FAULT_EN
    localparam logic [A_WIDTH-1:0] ROM_LAST = RESET_VECTOR + ROM_BYTES - A_WIDTH'(4);

    function automatic logic in_rom(input logic [A_WIDTH-1:0] a);
        return (a[1:0] == 2'b00) && (a >= RESET_VECTOR) && (a <= ROM_LAST);
    endfunction

    // Illegal targets are still loaded so the PC shows the offending address.
    assign target_c      = bus.redirect_target;
    assign redirect_ok_c = in_rom(bus.redirect_target);
    assign pc_ok_c       = in_rom(pc);
`else
    assign target_c      = {bus.redirect_target[A_WIDTH-1:2], 2'b00};
    assign redirect_ok_c = 1'b1;
    assign pc_ok_c       = 1'b1;
`endif

    // The IF/ID slot is free when empty or being consumed this cycle.
    always_comb begin
        advance_c = (state_q != HALT) && (!id_valid_q || bus.id_ready);
        pc_sel_c  = PC_HOLD;
        if (bus.redirect_valid) begin
            pc_sel_c = PC_REDIRECT;
        end else if (advance_c && pc_ok_c) begin
            pc_sel_c = PC_INC;
        end
    end

    pc_reg #(
        .A_WIDTH      (A_WIDTH),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_reg (
        .clk             (clk),
        .rst             (rst),
        .pc_sel          (pc_sel_c),
        .redirect_target (target_c),
        .pc              (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            id_valid_q    <= 1'b0;
            id_instr_q    <= NOP_INSTR;
            id_pc_q       <= RESET_VECTOR;
            id_pc_plus4_q <= RESET_VECTOR + A_WIDTH'(4);
            fault_q       <= 1'b0;
        end else if (bus.redirect_valid) begin
            // Redirect flushes the slot, even an unaccepted stalled instruction.
            id_valid_q <= 1'b0;
            state_q    <= redirect_ok_c ? FETCH : HALT;
            fault_q    <= !redirect_ok_c;
        end else begin
            case (state_q)
                FETCH, STALL: begin
                    if (advance_c) begin
                        if (pc_ok_c) begin
                            id_instr_q    <= bus.imem_data;
                            id_pc_q       <= pc;
                            id_pc_plus4_q <= pc + A_WIDTH'(4);
                            id_valid_q    <= 1'b1;
                            state_q       <= FETCH;
                        end else begin
                            id_valid_q <= 1'b0;
                            fault_q    <= 1'b1;
                            state_q    <= HALT;
                        end
                    end else begin
                        state_q <= STALL;
                    end
                end
                HALT:    state_q <= HALT;
                default: state_q <= FETCH;
            endcase
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.id_valid    = id_valid_q;
    assign bus.id_instr    = id_instr_q;
    assign bus.id_pc       = id_pc_q;
    assign bus.id_pc_plus4 = id_pc_plus4_q;
    assign bus.fetch_fault = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, corner sequences, random vs model.
module tb_instr_fetch;

    localparam int unsigned AW   = 32;
    localparam logic [31:0] RV   = 32'hBFC0_0000;
    localparam logic [31:0] ROMB = 32'h0000_1000;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] I0   = 32'h0050_0093;

    logic clk;
    logic rst;

    instr_fetch_if #(.A_WIDTH(AW)) ifc ();

    instr_fetch #(
        .A_WIDTH      (AW),
        .RESET_VECTOR (RV),
        .ROM_BYTES    (ROMB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == RV) return I0;
        return {a[17:2], 16'h0013};
    endfunction

    assign ifc.imem_data = rom_word(ifc.imem_addr);

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [31:0] epc,
                           input logic [31:0] einstr, input logic [31:0] eaddr, input logic ef);
        chk({tag, " id_valid"},    32'(ifc.id_valid),    32'(ev));
        chk({tag, " id_pc"},       ifc.id_pc,            epc);
        chk({tag, " id_pc_plus4"}, ifc.id_pc_plus4,      epc + 32'd4);
        chk({tag, " id_instr"},    ifc.id_instr,         einstr);
        chk({tag, " imem_addr"},   ifc.imem_addr,        eaddr);
        chk({tag, " fetch_fault"}, 32'(ifc.fetch_fault), 32'(ef));
    endtask

    task automatic drive(input logic r, input logic rdy, input logic rv, input logic [31:0] rt);
        rst                 = r;
        ifc.id_ready        = rdy;
        ifc.redirect_valid  = rv;
        ifc.redirect_target = rt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rt;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [31:0] eaddr;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic r, input logic rdy, input logic rv, input logic [31:0] rt,
                                input logic ev, input logic [31:0] epc, input logic [31:0] ei,
                                input logic [31:0] ea);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.rv = rv; v.rt = rt;
        v.ev = ev; v.epc = epc; v.einstr = ei; v.eaddr = ea;
        return v;
    endfunction

    // Reference model: transaction-level view of the IF/ID slot and the fetch pointer.
    logic [31:0] m_pc, m_idpc, m_instr;
    logic        m_valid, m_halt;

    function automatic logic legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= RV) && (a <= RV + ROMB - 32'd4);
    endfunction

    task automatic model_step(input logic r, input logic rdy, input logic rv, input logic [31:0] rt);
        logic fault_en;
`ifdef FETCH_FAULT_EN
        fault_en = 1'b1;
`else
        fault_en = 1'b0;
`endif
        if (r) begin
            m_pc = RV; m_idpc = RV; m_instr = NOP; m_valid = 1'b0; m_halt = 1'b0;
        end else if (rv) begin
            m_pc    = fault_en ? rt : (rt & ~32'd3);
            m_valid = 1'b0;
            m_halt  = fault_en && !legal(rt);
        end else if (!m_halt && (!m_valid || rdy)) begin
            if (fault_en && !legal(m_pc)) begin
                m_halt  = 1'b1;
                m_valid = 1'b0;
            end else begin
                m_instr = rom_word(m_pc);
                m_idpc  = m_pc;
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        drive(1'b1, 1'b1, 1'b0, 32'h0);

        // Reset release, streaming, 3-cycle stall, redirect while stalled, reset mid-stream.
        vt.push_back(mk(1, 1, 0, 0,            0, RV,         NOP,                    RV));
        vt.push_back(mk(0, 1, 0, 0,            1, RV,         I0,                     RV + 32'h04));
        vt.push_back(mk(0, 1, 0, 0,            1, RV + 32'h04, rom_word(RV + 32'h04), RV + 32'h08));
        vt.push_back(mk(0, 1, 0, 0,            1, RV + 32'h08, rom_word(RV + 32'h08), RV + 32'h0C));
        vt.push_back(mk(0, 0, 0, 0,            1, RV + 32'h08, rom_word(RV + 32'h08), RV + 32'h0C));
        vt.push_back(mk(0, 0, 0, 0,            1, RV + 32'h08, rom_word(RV + 32'h08), RV + 32'h0C));
        vt.push_back(mk(0, 0, 0, 0,            1, RV + 32'h08, rom_word(RV + 32'h08), RV + 32'h0C));
        vt.push_back(mk(0, 1, 0, 0,            1, RV + 32'h0C, rom_word(RV + 32'h0C), RV + 32'h10));
        vt.push_back(mk(0, 1, 0, 0,            1, RV + 32'h10, rom_word(RV + 32'h10), RV + 32'h14));
        vt.push_back(mk(0, 0, 0, 0,            1, RV + 32'h10, rom_word(RV + 32'h10), RV + 32'h14));
        vt.push_back(mk(0, 0, 1, RV + 32'h40,  0, RV + 32'h10, rom_word(RV + 32'h10), RV + 32'h40));
        vt.push_back(mk(0, 0, 0, 0,            1, RV + 32'h40, rom_word(RV + 32'h40), RV + 32'h44));
        vt.push_back(mk(0, 0, 0, 0,            1, RV + 32'h40, rom_word(RV + 32'h40), RV + 32'h44));
        vt.push_back(mk(0, 1, 0, 0,            1, RV + 32'h44, rom_word(RV + 32'h44), RV + 32'h48));
        vt.push_back(mk(0, 1, 1, RV + 32'h80,  0, RV + 32'h44, rom_word(RV + 32'h44), RV + 32'h80));
        vt.push_back(mk(0, 1, 0, 0,            1, RV + 32'h80, rom_word(RV + 32'h80), RV + 32'h84));
        vt.push_back(mk(0, 1, 1, RV + 32'h1C,  0, RV + 32'h80, rom_word(RV + 32'h80), RV + 32'h1C));
        vt.push_back(mk(0, 1, 0, 0,            1, RV + 32'h1C, rom_word(RV + 32'h1C), RV + 32'h20));
        vt.push_back(mk(1, 1, 0, 0,            0, RV,         NOP,                    RV));
        vt.push_back(mk(0, 1, 0, 0,            1, RV,         I0,                     RV + 32'h04));

        foreach (vt[i]) begin
            drive(vt[i].rst, vt[i].rdy, vt[i].rv, vt[i].rt);
            tick();
            chk_all($sformatf("vec%0d", i), vt[i].ev, vt[i].epc, vt[i].einstr, vt[i].eaddr, 1'b0);
        end

`ifdef FETCH_FAULT_EN
        drive(0, 1, 1, RV + 32'h42); tick();
        chk_all("misalign_redir", 0, RV, I0, RV + 32'h42, 1);
        drive(0, 1, 0, 0); tick();
        chk_all("halt_hold1", 0, RV, I0, RV + 32'h42, 1);
        tick();
        chk_all("halt_hold2", 0, RV, I0, RV + 32'h42, 1);
        drive(0, 1, 1, RV); tick();
        chk_all("halt_exit", 0, RV, I0, RV, 0);
        drive(0, 1, 0, 0); tick();
        chk_all("resume", 1, RV, I0, RV + 32'h04, 0);
        drive(0, 1, 1, RV + 32'hFFC); tick();
        chk_all("to_rom_top", 0, RV, I0, RV + 32'hFFC, 0);
        drive(0, 1, 0, 0); tick();
        chk_all("rom_top_fetch", 1, RV + 32'hFFC, rom_word(RV + 32'hFFC), RV + 32'h1000, 0);
        tick();
        chk_all("rom_top_halt", 0, RV + 32'hFFC, rom_word(RV + 32'hFFC), RV + 32'h1000, 1);
        drive(0, 1, 1, RV - 32'd4); tick();
        chk_all("below_rom_redir", 0, RV + 32'hFFC, rom_word(RV + 32'hFFC), RV - 32'd4, 1);
        drive(0, 1, 1, RV + 32'h08); tick();
        chk_all("legal_exit", 0, RV + 32'hFFC, rom_word(RV + 32'hFFC), RV + 32'h08, 0);
        drive(0, 1, 0, 0); tick();
        chk_all("after_exit", 1, RV + 32'h08, rom_word(RV + 32'h08), RV + 32'h0C, 0);
`else
        drive(0, 1, 1, RV + 32'h42); tick();
        chk_all("misalign_redir", 0, RV, I0, RV + 32'h40, 0);
        drive(0, 1, 0, 0); tick();
        chk_all("misalign_fetch", 1, RV + 32'h40, rom_word(RV + 32'h40), RV + 32'h44, 0);
        drive(0, 1, 1, 32'hFFFF_FFFC); tick();
        chk_all("wrap_redir", 0, RV + 32'h40, rom_word(RV + 32'h40), 32'hFFFF_FFFC, 0);
        drive(0, 1, 0, 0); tick();
        chk_all("wrap_top", 1, 32'hFFFF_FFFC, rom_word(32'hFFFF_FFFC), 32'h0, 0);
        tick();
        chk_all("wrap_zero", 1, 32'h0, rom_word(32'h0), 32'h4, 0);
`endif

        // Stall, then reset together with a redirect: reset wins.
        drive(0, 0, 0, 0); tick(); tick();
        drive(1, 0, 1, RV + 32'h100); tick();
        chk_all("rst_over_redir", 0, RV, NOP, RV, 0);

        // Random traffic against the model.
        model_step(1, 1, 0, 0);
        drive(1, 1, 0, 0); tick();
        for (int n = 0; n < 600; n++) begin
            logic        r, rdy, rv;
            logic [31:0] rt;
            int unsigned sel;
            r   = ($urandom_range(0, 63) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 7) == 0);
            sel = $urandom_range(0, 9);
            rt  = RV + (32'($urandom_range(0, 1023)) << 2);
            if (sel == 6) rt = RV + (32'($urandom_range(1016, 1023)) << 2);
            if (sel == 7) rt = rt + 32'($urandom_range(1, 3));
            if (sel == 8) rt = RV + ROMB + (32'($urandom_range(0, 255)) << 2);
            if (sel == 9) rt = 32'($urandom());
            model_step(r, rdy, rv, rt);
            drive(r, rdy, rv, rt);
            tick();
            chk_all($sformatf("rand%0d", n), m_valid, m_idpc, m_instr, m_pc, m_halt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
